// File: rtl/uart_rom_loader.sv
// Turns a framed UART byte stream into sequential Hack ROM writes, holding the CPU in reset
// from sync until a good checksum. Frame: SYNC, LEN_H, LEN_L, N x (HI, LO), CHK.
module uart_rom_loader #(
   parameter int unsigned ADDR_W    = 15,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 1_200_000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rcv,
   input  logic [7:0]        data,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       rom_wdata,
   output logic              cpu_rstn,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned TMO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned MAX_WORDS = 1 << ADDR_W;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

   typedef enum logic [3:0] {
      IDLE, LEN_H, LEN_L, W_HI, W_LO, WRITE, CHK, DONE, ERR
   } state_t;

   state_t           state;
   logic [15:0]      count;
   logic [7:0]       csum;
   logic [TMO_W-1:0] tmo;
   logic [15:0]      len_c;
   logic             rx_state_c;
   logic             tmo_hit_c;

   // States that wait for a byte and are therefore subject to the inter-byte timeout
   assign rx_state_c = (state == LEN_H) || (state == LEN_L) || (state == W_HI) ||
                       (state == W_LO)  || (state == CHK);
   assign tmo_hit_c  = rx_state_c && !rcv && (tmo == TMO_LAST);
   assign len_c      = {count[15:8], data};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rom_we    <= 1'b0;
         rom_addr  <= '0;
         rom_wdata <= '0;
         cpu_rstn  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'd0;
         count     <= '0;
         csum      <= '0;
         tmo       <= '0;
      end else begin
         rom_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;

         // Accepted bytes feed the checksum; a byte dropped during WRITE is not accepted
         if (rx_state_c && rcv) begin
            csum <= csum + data;
            tmo  <= '0;
         end else if (rx_state_c || state == WRITE) begin
            tmo <= tmo + TMO_W'(1);
         end

         case (state)
            IDLE: begin
               if (rcv && data == SYNC_BYTE) begin
                  state    <= LEN_H;
                  busy     <= 1'b1;
                  cpu_rstn <= 1'b0;
                  err_code <= 2'd0;
                  csum     <= '0;
                  rom_addr <= '0;
                  tmo      <= '0;
               end
            end
            LEN_H: begin
               if (rcv) begin
                  count[15:8] <= data;
                  state       <= LEN_L;
               end
            end
            LEN_L: begin
               if (rcv) begin
                  count <= len_c;
                  if (32'(len_c) > MAX_WORDS) begin
                     state    <= ERR;
                     err      <= 1'b1;
                     err_code <= 2'd3;
                  end else if (len_c == 16'd0) begin
                     state <= CHK;
                  end else begin
                     state <= W_HI;
                  end
               end
            end
            W_HI: begin
               if (rcv) begin
                  rom_wdata[15:8] <= data;
                  state           <= W_LO;
               end
            end
            W_LO: begin
               if (rcv) begin
                  rom_wdata[7:0] <= data;
                  rom_we         <= 1'b1;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               // Address wraps to 0 naturally after a full 2**ADDR_W word load
               rom_addr <= rom_addr + ADDR_W'(1);
               count    <= count - 16'd1;
               state    <= (count == 16'd1) ? CHK : W_HI;
            end
            CHK: begin
               if (rcv) begin
                  if (data == csum) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= ERR;
                     err      <= 1'b1;
                     err_code <= 2'd2;
                  end
               end
            end
            DONE: begin
               cpu_rstn <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            ERR: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

         // Only reachable without rcv, so a byte arriving on the same edge always wins
         if (tmo_hit_c) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Scoreboard bench for uart_rom_loader: expected ROM writes and done/err pulses are queued
// as frames are sent and matched against DUT output events.
module tb_uart_rom_loader;

   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned TIMEOUT = 40;
   localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

   logic              clk = 1'b0;
   logic              rstn;
   logic              rcv;
   logic [7:0]        data;
   logic              rom_we;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_wdata;
   logic              cpu_rstn;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   typedef struct {
      int          kind;
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic [1:0]  code;
   } ev_t;

   ev_t         sb[$];
   logic [15:0] wbuf[16];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          t_last = 0;
   int          err_cyc = 0;
   logic        done_q = 1'b0;

   uart_rom_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn), .rcv(rcv), .data(data),
      .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
      .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: every rom_we/done/err pulse must match the head of the scoreboard
   always @(negedge clk) begin
      ev_t e;
      int  obs;
      if (rstn) begin
         if (done_q) check("cpu_release", 32'(cpu_rstn), 32'd1);
         done_q = done;
         if (rom_we || done || err) begin
            obs = rom_we ? EV_WR : (done ? EV_DONE : EV_ERR);
            if (sb.size() == 0) begin
               check("unexpected_evt", 32'(obs) + 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("evt_kind", 32'(obs), 32'(e.kind));
               check("cpu_held", 32'(cpu_rstn), 32'd0);
               if (obs == EV_WR) begin
                  check("wr_addr", 32'(rom_addr), 32'(e.addr));
                  check("wr_data", 32'(rom_wdata), 32'(e.wdata));
               end else if (obs == EV_DONE) begin
                  check("done_code", 32'(err_code), 32'd0);
               end else begin
                  check("err_code", 32'(err_code), 32'(e.code));
                  err_cyc = cyc;
               end
            end
         end
      end else begin
         done_q = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rcv    = 1'b1;
      data   = b;
      t_last = cyc;
      @(negedge clk);
      rcv  = 1'b0;
      data = 8'($urandom);
      repeat (2) @(negedge clk);
   endtask

   task automatic push_ev(input int kind, input int addr, input logic [15:0] wd, input logic [1:0] code);
      ev_t e;
      e.kind  = kind;
      e.addr  = 4'(addr);
      e.wdata = wd;
      e.code  = code;
      sb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Sends a complete frame built from wbuf; the checksum is the mod-256 sum of LEN and payload
   task automatic run_frame(input logic [15:0] len, input bit bad_chk);
      logic [7:0] sum;
      sum = 8'(len[15:8] + len[7:0]);
      send_byte(8'hA5);
      send_byte(len[15:8]);
      if (32'(len) > 32'd16) begin
         push_ev(EV_ERR, 0, 16'h0, 2'd3);
         send_byte(len[7:0]);
      end else begin
         send_byte(len[7:0]);
         for (int i = 0; i < int'(len); i++) begin
            push_ev(EV_WR, i, wbuf[i], 2'd0);
            send_byte(wbuf[i][15:8]);
            send_byte(wbuf[i][7:0]);
            sum = 8'(sum + wbuf[i][15:8] + wbuf[i][7:0]);
         end
         if (bad_chk) begin
            push_ev(EV_ERR, 0, 16'h0, 2'd2);
            send_byte(~sum);
         end else begin
            push_ev(EV_DONE, 0, 16'h0, 2'd0);
            send_byte(sum);
         end
      end
      drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      rcv  = 1'b0;
      data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_state", {rom_we, rom_addr, rom_wdata, cpu_rstn, busy, done, err, err_code},
            {1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Two-word load
      wbuf[0] = 16'h1234;
      wbuf[1] = 16'hABCD;
      run_frame(16'd2, 1'b0);
      check("after_load_cpu", 32'(cpu_rstn), 32'd1);
      check("after_load_busy", 32'(busy), 32'd0);

      // Empty frame
      run_frame(16'd0, 1'b0);
      check("empty_code", 32'(err_code), 32'd0);

      // Bad checksum keeps CPU in reset
      wbuf[0] = 16'hFFFF;
      run_frame(16'd1, 1'b1);
      check("chk_sticky", 32'(err_code), 32'd2);
      check("chk_cpu_held", 32'(cpu_rstn), 32'd0);

      // Timeout after a partial word
      push_ev(EV_ERR, 0, 16'h0, 2'd1);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h12);
      drain();
      check("tmo_latency", 32'(err_cyc - t_last), 32'(TIMEOUT));
      check("tmo_sticky", 32'(err_code), 32'd1);

      // Length 17 exceeds 2**ADDR_W
      run_frame(16'h0011, 1'b0);
      check("len_latency", 32'(err_cyc - t_last), 32'd1);
      check("len_sticky", 32'(err_code), 32'd3);
      check("len_cpu_held", 32'(cpu_rstn), 32'd0);

      // Full 16-word load, sync value inside payload, address wraps to 0
      for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
      wbuf[3] = 16'hA5A5;
      run_frame(16'd16, 1'b0);
      check("wrap_addr", 32'(rom_addr), 32'd0);
      check("full_cpu", 32'(cpu_rstn), 32'd1);

      // Noise before sync is ignored; async reset mid-payload
      send_byte(8'h00);
      send_byte(8'hFF);
      check("noise_busy", 32'(busy), 32'd0);
      push_ev(EV_WR, 0, 16'h1122, 2'd0);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_queue", 32'(sb.size()), 32'd0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("async_reset", {rom_we, rom_addr, rom_wdata, cpu_rstn, busy, done, err, err_code},
            {1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      wbuf[0] = 16'h5A5A;
      run_frame(16'd1, 1'b0);
      check("final_cpu", 32'(cpu_rstn), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
